sdram_write_master: RTL

Avalon-MM burst write initiator that returns execution-unit results to SDRAM; the write-direction counterpart of the existing SDRAM read path. It accepts a write command (byte address, beat count) from the control unit and a valid/ready data stream from an exec-unit group. Data is buffered in a local FIFO and emitted as one or more Avalon bursts of at most MAX_BURST beats each. A single-cycle `done` pulse signals completion to the control unit.

---
 rtl/sdram_pkg.sv | 18 +
 rtl/sdram_wr_fifo.sv | 68 ++++++
 rtl/sdram_write_master.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM path definitions: default widths and the burst-engine state type.
// Used by both the read and the write masters.
package sdram_pkg;

    localparam int unsigned SDRAM_ADDR_W        = 32;
    localparam int unsigned SDRAM_W             = 128;
    localparam int unsigned SDRAM_LEN_W         = 16;
    localparam int unsigned SDRAM_BURST_W       = 8;
    localparam int unsigned SDRAM_MAX_BURST     = 64;
    localparam int unsigned SDRAM_WR_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } sdram_state_e;

endpackage

// File: rtl/sdram_wr_fifo.sv
// Synchronous show-ahead FIFO for the SDRAM write path.
// Ports: clk, rst_n (async active-low), push/push_data (ignored when full),
//        pop (ignored when empty), head (current oldest entry, valid when !empty),
//        full, empty (registered flags).
// A push while full is dropped even if a pop happens in the same cycle, so
// the producer-side ready can be derived from the registered full flag.
module sdram_wr_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_d = count;
        case ({do_push, do_pop})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    // Pointers, occupancy and registered flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
            full  <= (count_d == CW'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    // Storage has no reset; contents are only observed through non-empty entries
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sdram_write_master.sv
// Avalon-MM burst write initiator returning exec-unit results to SDRAM.
// Accepts (byte address, beat count) commands, buffers a valid/ready data
// stream in a local FIFO and emits bursts of at most MAX_BURST beats.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   cmd_valid/cmd_ready,
//   cmd_addr, cmd_len           command handshake, start byte address, beats
//   wr_valid/wr_ready, wr_data  data stream (wr_ready = FIFO not full)
//   wr_strb                     byte strobes, only with SDRAM_WR_STRB_EN
//   avm_*                       Avalon-MM burst write master
//   busy, done                  not idle / one-cycle completion pulse
// Optional feature macro: SDRAM_WR_STRB_EN (per-beat strobes stored in the
// FIFO and driven on avm_byteenable; otherwise byteenable is all ones on writes).
module sdram_write_master
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_W     = SDRAM_ADDR_W,
    parameter int unsigned DATA_W     = SDRAM_W,
    parameter int unsigned LEN_W      = SDRAM_LEN_W,
    parameter int unsigned BURST_W    = SDRAM_BURST_W,
    parameter int unsigned MAX_BURST  = SDRAM_MAX_BURST,
    parameter int unsigned FIFO_DEPTH = SDRAM_WR_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [DATA_W-1:0]   wr_data,
`ifdef SDRAM_WR_STRB_EN
    input  logic [DATA_W/8-1:0] wr_strb,
`endif
    output logic [ADDR_W-1:0]   avm_address,
    output logic [BURST_W-1:0]  avm_burstcount,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic                avm_waitrequest,
    output logic                busy,
    output logic                done
);

    localparam int unsigned BE_W       = DATA_W / 8;
    localparam int unsigned BYTE_SHIFT = $clog2(BE_W);
`ifdef SDRAM_WR_STRB_EN
    localparam int unsigned FIFO_W = DATA_W + BE_W;
`else
    localparam int unsigned FIFO_W = DATA_W;
`endif

    sdram_state_e        state_q;
    sdram_state_e        state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    remaining_q;
    logic [BURST_W-1:0]  blen_q;
    logic [BURST_W-1:0]  beat_cnt_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic [FIFO_W-1:0]   fifo_din;
    logic [FIFO_W-1:0]   fifo_head;
    logic                fifo_push;

    logic                cmd_fire;
    logic                write_en;
    logic                beat;
    logic                last_beat;
    logic [LEN_W-1:0]    rem_after;

    // Beats in the next burst: min(n, MAX_BURST)
    function automatic logic [BURST_W-1:0] clip_burst(input logic [LEN_W-1:0] n);
        return (n > LEN_W'(MAX_BURST)) ? BURST_W'(MAX_BURST) : BURST_W'(n);
    endfunction

`ifdef SDRAM_WR_STRB_EN
    assign fifo_din       = {wr_strb, wr_data};
    assign avm_byteenable = write_en ? fifo_head[FIFO_W-1:DATA_W] : '0;
`else
    assign fifo_din       = wr_data;
    assign avm_byteenable = {BE_W{write_en}};
`endif

    sdram_wr_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_din),
        .pop       (beat),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wr_ready  = !fifo_full;
    assign fifo_push = wr_valid && !fifo_full;

    assign cmd_fire  = (state_q == IDLE) && cmd_valid;
    assign write_en  = (state_q == BURST) && !fifo_empty;
    assign beat      = write_en && !avm_waitrequest;
    assign last_beat = beat && (beat_cnt_q == blen_q - BURST_W'(1));
    assign rem_after = remaining_q - LEN_W'(blen_q);

    // Writedata is forced to zero outside write cycles so idle/reset outputs are clean
    assign avm_write      = write_en;
    assign avm_writedata  = write_en ? fifo_head[DATA_W-1:0] : '0;
    assign avm_address    = addr_q;
    assign avm_burstcount = blen_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and control outputs
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_d = (cmd_len == '0) ? DONE : BURST;
            end
            BURST: begin
                if (last_beat && (rem_after == '0)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst bookkeeping: address, remaining beats, burst length, beat index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            blen_q      <= '0;
            beat_cnt_q  <= '0;
        end else if (cmd_fire) begin
            addr_q      <= cmd_addr;
            remaining_q <= cmd_len;
            blen_q      <= clip_burst(cmd_len);
            beat_cnt_q  <= '0;
        end else if (beat) begin
            if (last_beat) begin
                remaining_q <= rem_after;
                addr_q      <= addr_q + (ADDR_W'(blen_q) << BYTE_SHIFT);
                blen_q      <= clip_burst(rem_after);
                beat_cnt_q  <= '0;
            end else begin
                beat_cnt_q  <= beat_cnt_q + BURST_W'(1);
            end
        end
    end

endmodule
